// File: rtl/bcd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bcd_ctrl_pkg
// Shared definitions for the two-digit BCD count controller:
//   - controller state encoding (IDLE, RUN, DONE)
//   - command opcode encoding carried on cmd_op
//   - BCD limits and the terminal value loaded at reset
//   - a helper that tells whether a byte holds two legal BCD digits
// No ports; imported by bcd_digit and bcd_count_ctrl.
// ---------------------------------------------------------------------------
package bcd_ctrl_pkg;

   // Controller state. The encoding is plain binary; the unused code 2'b11
   // is steered back to IDLE by the next-state logic.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Command opcodes as they appear on cmd_op.
   typedef enum logic [1:0] {
      OP_START = 2'b00,
      OP_STOP  = 2'b01,
      OP_CLEAR = 2'b10,
      OP_LOAD  = 2'b11
   } cmd_op_t;

   // Largest legal value of a single BCD digit.
   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

   // Terminal value held after reset, before any START has been accepted.
   localparam logic [7:0] RESET_TERM = 8'h99;

   // True when both nibbles of a packed {tens,ones} byte are legal digits.
   // START and LOAD use this to reject malformed cmd_data.
   function automatic logic is_bcd(input logic [7:0] value);
      return (value[7:4] <= BCD_MAX_DIGIT) && (value[3:0] <= BCD_MAX_DIGIT);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One registered 4-bit BCD digit. It can be loaded with an arbitrary digit,
// or stepped by one up (9 wraps to 0) or down (0 wraps to 9). carry_o flags
// that this step wraps the digit, so the next-higher digit should step too;
// chaining carry_o into the next digit's step_en_i builds a multi-digit
// decimal counter.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset, digit clears to 0
//   step_en_i    step the digit by one on this edge
//   down_i       step direction, 0 = up, 1 = down
//   load_i       replace the digit with load_val_i (wins over step_en_i)
//   load_val_i   digit value to load
//   digit_o      current digit
//   carry_o      carry (up) or borrow (down) out for the next digit
// ---------------------------------------------------------------------------
module bcd_digit
   import bcd_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       step_en_i,
   input  logic       down_i,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   output logic [3:0] digit_o,
   output logic       carry_o
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;

   // Next digit value. A load always wins over a step so that the controller
   // can overwrite the count (LOAD / CLEAR) on the same edge it would have
   // otherwise counted. Stepping wraps at the decimal limits rather than at
   // the 4-bit binary limits, which is what keeps the nibble a legal digit.
   always_comb begin
      digit_d = digit_q;
      if (load_i) begin
         digit_d = load_val_i;
      end else if (step_en_i) begin
         if (down_i) begin
            digit_d = (digit_q == 4'd0) ? BCD_MAX_DIGIT : (digit_q - 4'd1);
         end else begin
            digit_d = (digit_q == BCD_MAX_DIGIT) ? 4'd0 : (digit_q + 4'd1);
         end
      end
   end

   // Carry/borrow out is purely a function of the step request and the
   // present digit, so a chain of digits settles in one combinational pass
   // without any loop back into this digit.
   always_comb begin
      carry_o = 1'b0;
      if (step_en_i) begin
         carry_o = down_i ? (digit_q == 4'd0) : (digit_q == BCD_MAX_DIGIT);
      end
   end

   // Digit register, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit_o = digit_q;

endmodule

// File: rtl/bcd_count_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_count_ctrl
// Two-digit BCD counter with a small command interface. START arms a
// terminal value and begins counting, STOP pauses, CLEAR zeroes the count,
// LOAD overwrites the count. While running, the count steps once per clock
// until it equals the terminal value, then the controller spends exactly one
// cycle in DONE (done high, no commands accepted) and drops back to IDLE.
// START/LOAD with a non-BCD cmd_data are swallowed and pulse err.
//
// Build option:
//   DOWN_COUNT_EN  when defined, dir selects up (0) or down (1) counting,
//                  sampled on every step; otherwise the counter only counts
//                  up and dir is ignored.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   cmd_valid  a command is presented
//   cmd_ready  a command can be accepted this cycle (low only in DONE)
//   cmd_op     00 START, 01 STOP, 10 CLEAR, 11 LOAD
//   cmd_data   BCD {tens,ones}: terminal for START, count for LOAD
//   dir        count direction, 0 = up, 1 = down
//   count      current BCD count {tens,ones}
//   running    high while in RUN
//   done       one-cycle pulse when the terminal value is reached
//   err        one-cycle pulse when a command is rejected
// ---------------------------------------------------------------------------
module bcd_count_ctrl
   import bcd_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   input  logic       dir,
   output logic [7:0] count,
   output logic       running,
   output logic       done,
   output logic       err
);

   state_t     state_q;
   state_t     state_d;
   logic [7:0] term_q;
   logic [7:0] term_d;
   logic       err_q;
   logic       err_d;

   logic       cmd_accept;
   cmd_op_t    op;
   logic       data_ok;
   logic       step_down;

   logic       count_step;
   logic       count_load;
   logic [7:0] count_load_val;

   logic [3:0] ones_digit;
   logic [3:0] tens_digit;
   logic       ones_carry;
   logic       unused_tens_carry;

   // Direction selection. With down counting compiled out the dir pin is
   // still part of the interface but has no effect on the count.
`ifdef DOWN_COUNT_EN
   assign step_down = dir;
`else
   logic unused_dir;
   assign unused_dir = dir;
   assign step_down  = 1'b0;
`endif

   // The handshake only stalls during the single DONE cycle; everything else
   // about acceptance is a plain valid-and-ready.
   assign cmd_ready  = (state_q != ST_DONE);
   assign cmd_accept = cmd_valid && cmd_ready;
   assign op         = cmd_op_t'(cmd_op);
   assign data_ok    = is_bcd(cmd_data);
   assign count      = {tens_digit, ones_digit};

   // Next-state and count-control decode. An accepted command is handled
   // first and completely masks the RUN step and the terminal compare on that
   // edge; that is what makes START leave the count alone for one edge and
   // makes LOAD swallow the step. Without a command, RUN either finishes
   // (count already equals the terminal) or steps once. DONE always falls
   // straight back to IDLE after its single cycle. Rejected START/LOAD touch
   // nothing except the err pulse.
   always_comb begin
      state_d        = state_q;
      term_d         = term_q;
      err_d          = 1'b0;
      count_step     = 1'b0;
      count_load     = 1'b0;
      count_load_val = count;

      if (cmd_accept) begin
         case (op)
            OP_START: begin
               if (data_ok) begin
                  term_d  = cmd_data;
                  state_d = ST_RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_STOP: begin
               if (state_q == ST_RUN) begin
                  state_d = ST_IDLE;
               end
            end
            OP_CLEAR: begin
               count_load     = 1'b1;
               count_load_val = 8'h00;
               state_d        = ST_IDLE;
            end
            OP_LOAD: begin
               if (data_ok) begin
                  count_load     = 1'b1;
                  count_load_val = cmd_data;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end else begin
         case (state_q)
            ST_RUN: begin
               if (count == term_q) begin
                  state_d = ST_DONE;
               end else begin
                  count_step = 1'b1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Control registers: state, terminal value and the err pulse. Reset puts
   // the terminal at 99 so that a RUN entered without a fresh terminal still
   // has a well-defined stopping point.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         term_q  <= RESET_TERM;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         term_q  <= term_d;
         err_q   <= err_d;
      end
   end

   // Status outputs come from registered state only, so done and running are
   // glitch-free decodes and err is a registered one-cycle pulse.
   assign running = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign err     = err_q;

   // The ones digit steps whenever the controller asks; the tens digit steps
   // only on the ones digit's carry/borrow, giving 99->00 on the way up and
   // 00->99 on the way down with no special wrap handling here. The tens
   // carry-out has no consumer since wrap is not reported.
   bcd_digit u_ones (
      .clk        (clk),
      .reset_n    (reset_n),
      .step_en_i  (count_step),
      .down_i     (step_down),
      .load_i     (count_load),
      .load_val_i (count_load_val[3:0]),
      .digit_o    (ones_digit),
      .carry_o    (ones_carry)
   );

   bcd_digit u_tens (
      .clk        (clk),
      .reset_n    (reset_n),
      .step_en_i  (ones_carry),
      .down_i     (step_down),
      .load_i     (count_load),
      .load_val_i (count_load_val[7:4]),
      .digit_o    (tens_digit),
      .carry_o    (unused_tens_carry)
   );

endmodule
